nbody_step_sequencer: RTL and testbench
=======================================

NBODY_STEP_SEQUENCER -- requirements
Module: nbody_step_sequencer

Interface
REQ-001 SHALL take parameter NBODY, default 4, meaning the number of bodies, fixed to the 4-body 2x2 array.
REQ-002 SHALL take parameter SETTLE_CYCLES, default 8, meaning the clock cycles the array needs before a_1..a_4 are valid.
REQ-003 SHALL take parameter STEP_W, default 16, meaning the timestep counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: begin a run of n_steps timesteps.
REQ-007 SHALL have port n_steps, input, STEP_W bits: timesteps to run, sampled at start.
REQ-008 SHALL have port dt, input, real: timestep, sampled at start.
REQ-009 SHALL have ports load_valid (input, 1 bit), load_idx (input, 2 bits), load_q (input, real) and load_m (input, real): body initial-state write.
REQ-010 SHALL have ports q_1..q_4 and m_1..m_4, output, real: positions and masses driven to the array.
REQ-011 SHALL have ports a_1..a_4, input, real: accelerations from the array.
REQ-012 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking run completion.
REQ-014 SHALL have port step_count, output, STEP_W bits: timesteps completed in the current or last run.

Function
REQ-015 SHALL use states IDLE, SETTLE, CAPTURE, INTEGRATE and DONE.
REQ-016 Loading: in IDLE, load_valid SHALL write q_t[idx] = q_told[idx] = load_q and m[idx] = load_m (zero initial velocity).
REQ-017 load_valid SHALL be ignored in every state other than IDLE.
REQ-018 IDLE: start with n_steps != 0 SHALL latch n_steps and dt, clear step_count, and go to SETTLE.
REQ-019 IDLE: start with n_steps == 0 SHALL pulse done on the next cycle and leave all other state unchanged.
REQ-020 SETTLE SHALL hold q/m outputs constant for exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-021 CAPTURE SHALL latch a_1..a_4 into internal registers for 1 cycle, then go to INTEGRATE.
REQ-022 INTEGRATE SHALL run 4 cycles with body index k = 0..3 and compute shadow q_new[k] = 2*q_t[k] - q_told[k] + a[k]*dt*dt.
REQ-023 On the last INTEGRATE cycle, all bodies SHALL commit simultaneously: q_told <= q_t, q_t <= q_new, step_count += 1.
REQ-024 q_1..q_4 SHALL never show a partially updated set.
REQ-025 After commit, the FSM SHALL go to DONE if step_count equals the latched n_steps, otherwise to SETTLE.
REQ-026 DONE SHALL last 1 cycle with done = 1, then return to IDLE; step_count and positions SHALL be held.
REQ-027 Per-step latency SHALL be SETTLE_CYCLES + 5 cycles, and done SHALL assert n_steps*(SETTLE_CYCLES+5) cycles after the start edge.
REQ-028 busy SHALL be 1 in SETTLE, CAPTURE and INTEGRATE, and 0 in IDLE and DONE.
REQ-029 start while busy SHALL be ignored, with no restart and no change to the latched n_steps or dt.
REQ-030 Masses SHALL be constant during a run.
REQ-031 q_t/q_told SHALL be kept at real precision with no saturation.
REQ-032 step_count SHALL not wrap, because n_steps bounds it.

Reset
REQ-033 rst SHALL force IDLE immediately, including mid-run.
REQ-034 Reset SHALL clear busy, done and step_count to 0, and set all q_t, q_told, m, shadow and latched a registers, and the q/m outputs, to 0.0.
REQ-035 An interrupted run SHALL not resume after reset; the bodies SHALL be reloaded.

Structure
REQ-036 A shared package SHALL hold the state enum type, NBODY, the default SETTLE_CYCLES and STEP_W.
REQ-037 The Verlet update SHALL be one instance of the existing integration sub-module, systolic_n_body_2x2_integration, time-multiplexed over k; the datapath SHALL not be duplicated.
REQ-038 The FSM and the cycle counters SHALL stay in this module.

Verification
REQ-039 Load q = -2, -1, 1, 2 and m = 1; mock array drives a = 1.0; dt = 0.1; n_steps = 1 -> q = -1.99, -0.99, 1.01, 2.01 and done 13 cycles after start.
REQ-040 From q = 0, a = 1.0, dt = 0.1, n_steps = 2 -> q = 0.01 after step 1, q = 0.03 after step 2, step_count = 2.
REQ-041 start with n_steps = 0 -> done pulses on the next cycle, busy stays 0 and q is unchanged.
REQ-042 start and load_valid pulsed mid-run -> both ignored; final q equals the same run without these pulses.
REQ-043 rst asserted during INTEGRATE -> outputs are 0.0 and busy = 0 in the same cycle, and the FSM is in IDLE.
REQ-044 Mock a changes during SETTLE but is stable at CAPTURE -> the update uses only the CAPTURE-cycle value.

Source files
------------

// File: rtl/nbody_step_sequencer_pkg.sv
// Shared types and defaults for the 4-body timestep sequencer.
// Holds the FSM state type and the fixed body count.
package nbody_step_sequencer_pkg;

    localparam int P_NBODY         = 4;
    localparam int P_SETTLE_CYCLES = 8;
    localparam int P_STEP_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_INTEGRATE = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/systolic_n_body_2x2_integration.sv
// Position Verlet update for one body.
// Purely combinational, so it can be shared across bodies.
module systolic_n_body_2x2_integration (
    input  real i_q_t,
    input  real i_q_told,
    input  real i_a,
    input  real i_dt,
    output real o_q_new
);

    assign o_q_new = 2.0 * i_q_t - i_q_told + i_a * i_dt * i_dt;

endmodule

// File: rtl/nbody_step_sequencer.sv
// Sequences Verlet timesteps for a 4-body 2x2 force array: settle, capture
// accelerations, integrate each body in turn, then commit all positions at once.
module nbody_step_sequencer
    import nbody_step_sequencer_pkg::*;
#(
    parameter int NBODY         = P_NBODY,
    parameter int SETTLE_CYCLES = P_SETTLE_CYCLES,
    parameter int STEP_W        = P_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] n_steps,
    input  real               dt,
    input  logic              load_valid,
    input  logic [1:0]        load_idx,
    input  real               load_q,
    input  real               load_m,
    output real               q_1,
    output real               q_2,
    output real               q_3,
    output real               q_4,
    output real               m_1,
    output real               m_2,
    output real               m_3,
    output real               m_4,
    input  real               a_1,
    input  real               a_2,
    input  real               a_3,
    input  real               a_4,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_count,
    output logic [2:0]        o_state
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_settle_cnt;
    logic [1:0]        r_k;
    logic [STEP_W-1:0] r_n_steps;
    logic [STEP_W-1:0] r_step_count;
    real               r_dt;
    real               r_q_t    [NBODY];
    real               r_q_told [NBODY];
    real               r_m      [NBODY];
    real               r_a      [NBODY];
    real               r_q_new  [NBODY];
    real               w_a_in   [NBODY];
    real               w_q_new;
    logic [STEP_W-1:0] w_step_next;

    assign w_a_in[0]   = a_1;
    assign w_a_in[1]   = a_2;
    assign w_a_in[2]   = a_3;
    assign w_a_in[3]   = a_4;
    assign w_step_next = r_step_count + 1'b1;

    systolic_n_body_2x2_integration u_integ (
        .i_q_t    (r_q_t[r_k]),
        .i_q_told (r_q_told[r_k]),
        .i_a      (r_a[r_k]),
        .i_dt     (r_dt),
        .o_q_new  (w_q_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_k          <= '0;
            r_n_steps    <= '0;
            r_step_count <= '0;
            r_dt         <= 0.0;
            for (int i = 0; i < NBODY; i++) begin
                r_q_t[i]    <= 0.0;
                r_q_told[i] <= 0.0;
                r_m[i]      <= 0.0;
                r_a[i]      <= 0.0;
                r_q_new[i]  <= 0.0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_q_t[load_idx]    <= load_q;
                        r_q_told[load_idx] <= load_q;
                        r_m[load_idx]      <= load_m;
                    end
                    if (start) begin
                        if (n_steps != '0) begin
                            r_n_steps    <= n_steps;
                            r_dt         <= dt;
                            r_step_count <= '0;
                            r_settle_cnt <= '0;
                            r_state      <= ST_SETTLE;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    for (int i = 0; i < NBODY; i++) begin
                        r_a[i] <= w_a_in[i];
                    end
                    r_k     <= '0;
                    r_state <= ST_INTEGRATE;
                end
                ST_INTEGRATE: begin
                    r_q_new[r_k] <= w_q_new;
                    if (r_k == 2'd3) begin
                        // Last body is taken straight from the datapath so every
                        // position flips on the same edge.
                        for (int i = 0; i < NBODY; i++) begin
                            r_q_told[i] <= r_q_t[i];
                            r_q_t[i]    <= (i == NBODY - 1) ? w_q_new : r_q_new[i];
                        end
                        r_step_count <= w_step_next;
                        if (w_step_next == r_n_steps) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_settle_cnt <= '0;
                            r_state      <= ST_SETTLE;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign q_1        = r_q_t[0];
    assign q_2        = r_q_t[1];
    assign q_3        = r_q_t[2];
    assign q_4        = r_q_t[3];
    assign m_1        = r_m[0];
    assign m_2        = r_m[1];
    assign m_3        = r_m[2];
    assign m_4        = r_m[3];
    assign busy       = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE) ||
                        (r_state == ST_INTEGRATE);
    assign done       = (r_state == ST_DONE);
    assign step_count = r_step_count;
    assign o_state    = r_state;

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Self-checking bench for nbody_step_sequencer with a mock force array.
// Expected positions come from a Verlet model and are queued per run.
module tb_nbody_step_sequencer;
    import nbody_step_sequencer_pkg::*;

    localparam int SC       = 8;
    localparam int STEP_LAT = SC + 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n_steps;
    real         dt;
    logic        load_valid;
    logic [1:0]  load_idx;
    real         load_q;
    real         load_m;
    real         q_1, q_2, q_3, q_4;
    real         m_1, m_2, m_3, m_4;
    real         a_1, a_2, a_3, a_4;
    logic        busy;
    logic        done;
    logic [15:0] step_count;
    logic [2:0]  state_dbg;

    int  n_vec  = 0;
    int  n_miss = 0;
    real exp_q[$];
    real mq[4];
    real mqo[4];

    int  cyc;
    int  qchg;
    int  bseen;
    real qlat;

    nbody_step_sequencer #(.NBODY(4), .SETTLE_CYCLES(SC), .STEP_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_steps    (n_steps),
        .dt         (dt),
        .load_valid (load_valid),
        .load_idx   (load_idx),
        .load_q     (load_q),
        .load_m     (load_m),
        .q_1        (q_1),
        .q_2        (q_2),
        .q_3        (q_3),
        .q_4        (q_4),
        .m_1        (m_1),
        .m_2        (m_2),
        .m_3        (m_3),
        .m_4        (m_4),
        .a_1        (a_1),
        .a_2        (a_2),
        .a_3        (a_3),
        .a_4        (a_4),
        .busy       (busy),
        .done       (done),
        .step_count (step_count),
        .o_state    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input real got, input real exp);
        n_vec++;
        if ((got - exp) > 1.0e-9 || (exp - got) > 1.0e-9) begin
            n_miss++;
            $display("FAIL %s: got %g, expected %g", tag, got, exp);
        end
    endtask

    task automatic set_a(input real v);
        a_1 = v; a_2 = v; a_3 = v; a_4 = v;
    endtask

    task automatic load_body(input int idx, input real q, input real m);
        load_valid = 1'b1;
        load_idx   = 2'(idx);
        load_q     = q;
        load_m     = m;
        @(posedge clk); #1;
        load_valid = 1'b0;
        mq[idx]  = q;
        mqo[idx] = q;
    endtask

    task automatic model_run(input int n, input real a, input real dt_v);
        real tmp;
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < 4; i++) begin
                tmp    = 2.0 * mq[i] - mqo[i] + a * dt_v * dt_v;
                mqo[i] = mq[i];
                mq[i]  = tmp;
            end
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(mq[i]);
    endtask

    // Starts a run and waits for done; inj1/inj2 are cycles at which stray
    // start/load pulses are driven (-1 for none).
    task automatic run(input int n, input real dt_v, input int inj1, input int inj2,
                       output int cycles, output int qc, output int bs, output real ql);
        real prev;
        n_steps = 16'(n);
        dt      = dt_v;
        start   = 1'b1;
        cycles  = -1;
        qc      = 0;
        bs      = 0;
        ql      = 0.0;
        prev    = q_1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            start      = 1'b0;
            load_valid = 1'b0;
            n_steps    = 16'(n);
            dt         = dt_v;
            if (i == inj1 || i == inj2) begin
                start      = 1'b1;
                load_valid = 1'b1;
                load_idx   = 2'd0;
                load_q     = 99.0;
                load_m     = 5.0;
                n_steps    = 16'd7;
                dt         = 0.5;
            end
            if (q_1 != prev) qc++;
            prev = q_1;
            if (busy) bs = 1;
            if (i == STEP_LAT) ql = q_1;
            if (done) begin
                cycles = i;
                break;
            end
        end
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int n);
        real got[4];
        real e;
        got[0] = q_1; got[1] = q_2; got[2] = q_3; got[3] = q_4;
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 1.0, 0.0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_q%0d", tag, i + 1), got[i], e);
            end
        end
        check({tag, "_step_count"}, real'(step_count), real'(n));
        check({tag, "_busy_in_done"}, real'(busy), 0.0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, real'(done), 0.0);
        check({tag, "_back_idle"}, real'(state_dbg), real'(int'(ST_IDLE)));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_steps = '0; dt = 0.0;
        load_valid = 1'b0; load_idx = '0; load_q = 0.0; load_m = 0.0;
        set_a(0.0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", real'(busy), 0.0);
        check("rst_done", real'(done), 0.0);
        check("rst_step_count", real'(step_count), 0.0);
        check("rst_q1", q_1, 0.0);
        check("rst_m4", m_4, 0.0);
        check("rst_state", real'(state_dbg), real'(int'(ST_IDLE)));
        rst = 1'b0;
        @(posedge clk); #1;

        // Single step from a spread of positions
        load_body(0, -2.0, 1.0); load_body(1, -1.0, 1.0);
        load_body(2, 1.0, 1.0);  load_body(3, 2.0, 1.0);
        set_a(1.0);
        exp_q.push_back(-1.99); exp_q.push_back(-0.99);
        exp_q.push_back(1.01);  exp_q.push_back(2.01);
        run(1, 0.1, -1, -1, cyc, qchg, bseen, qlat);
        check("t1_latency", real'(cyc), real'(STEP_LAT));
        check("t1_q_changes", real'(qchg), 1.0);
        check("t1_busy_seen", real'(bseen), 1.0);
        check("t1_m1", m_1, 1.0);
        finish_run("t1", 1);

        // Two steps from rest
        for (int i = 0; i < 4; i++) load_body(i, 0.0, 2.0);
        model_run(2, 1.0, 0.1);
        run(2, 0.1, -1, -1, cyc, qchg, bseen, qlat);
        check("t2_latency", real'(cyc), real'(2 * STEP_LAT));
        check("t2_q_after_step1", qlat, 0.01);
        check("t2_q_after_step2", q_1, 0.03);
        check("t2_q_changes", real'(qchg), 2.0);
        check("t2_m3", m_3, 2.0);
        finish_run("t2", 2);

        // Zero-step run: immediate done, nothing else moves
        run(0, 0.7, -1, -1, cyc, qchg, bseen, qlat);
        check("t3_latency", real'(cyc), 0.0);
        check("t3_busy_seen", real'(bseen), 0.0);
        check("t3_q1", q_1, 0.03);
        check("t3_q4", q_4, 0.03);
        check("t3_step_count", real'(step_count), 2.0);
        @(posedge clk); #1;
        check("t3_done_pulse", real'(done), 0.0);

        // Stray start and load pulses in SETTLE and INTEGRATE
        load_body(0, -2.0, 1.0); load_body(1, -1.0, 1.0);
        load_body(2, 1.0, 1.0);  load_body(3, 2.0, 1.0);
        set_a(1.0);
        model_run(2, 1.0, 0.1);
        run(2, 0.1, 5, 11, cyc, qchg, bseen, qlat);
        check("t4_latency", real'(cyc), real'(2 * STEP_LAT));
        check("t4_m1", m_1, 1.0);
        finish_run("t4", 2);

        // Acceleration wanders during SETTLE and after CAPTURE
        for (int i = 0; i < 4; i++) load_body(i, 0.5, 1.0);
        set_a(5.0);
        model_run(1, 1.0, 0.2);
        fork
            run(1, 0.2, -1, -1, cyc, qchg, bseen, qlat);
            begin
                for (int i = 0; i < STEP_LAT; i++) begin
                    @(posedge clk); #1;
                    if (i < SC) set_a(real'($urandom_range(0, 100)) / 10.0 + 2.0);
                    else if (i == SC) set_a(1.0);
                    else set_a(7.0);
                end
            end
        join
        check("t5_latency", real'(cyc), real'(STEP_LAT));
        finish_run("t5", 1);
        set_a(1.0);

        // Reset in the middle of INTEGRATE
        n_steps = 16'd1;
        dt      = 0.1;
        start   = 1'b1;
        for (int i = 0; i <= SC + 2; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("t6_in_integrate", real'(state_dbg), real'(int'(ST_INTEGRATE)));
        rst = 1'b1;
        #1;
        check("t6_q1", q_1, 0.0);
        check("t6_q2", q_2, 0.0);
        check("t6_q3", q_3, 0.0);
        check("t6_q4", q_4, 0.0);
        check("t6_m2", m_2, 0.0);
        check("t6_busy", real'(busy), 0.0);
        check("t6_done", real'(done), 0.0);
        check("t6_step_count", real'(step_count), 0.0);
        check("t6_state", real'(state_dbg), real'(int'(ST_IDLE)));
        @(negedge clk);
        rst = 1'b0;
        qchg = 0;
        for (int i = 0; i < 2 * STEP_LAT; i++) begin
            @(posedge clk); #1;
            if (busy || done) qchg++;
        end
        check("t6_no_resume", real'(qchg), 0.0);
        check("t6_q1_after", q_1, 0.0);

        check("queue_drained", real'(exp_q.size()), 0.0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
